l2_axi_bridge: RTL and testbench

Memory-side bridge directly downstream of the L2 cache. Converts the L2-Mem line port (read refills, dirty-line writebacks, uncached single-word accesses) into AXI4 bursts on one 32-bit master interface. One transaction in flight at a time; writes take priority over reads so a writeback always precedes the refill it makes room for.

---
 rtl/l2_axi_bridge.sv | 183 ++++++++++++++++++
 tb/tb_l2_axi_bridge.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_axi_bridge.sv
// L2 memory-side bridge: turns L2 line refills, writebacks and uncached word
// accesses into single AXI4 INCR bursts, one transaction in flight at a time.
module l2_axi_bridge #(
  parameter int offset_width = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [31:0]                   addr_l2cache_mem_r,
  input  logic [31:0]                   addr_l2cache_mem_w,
  input  logic [(32<<offset_width)-1:0] dout_l2cache_mem,
  output logic [(32<<offset_width)-1:0] din_mem_l2cache,
  input  logic                          l2cache_mem_req_r,
  input  logic                          l2cache_mem_req_w,
  input  logic                          l2cache_mem_rdy,
  input  logic                          l2cache_mem_SUC,
  input  logic [3:0]                    l2cache_mem_wstrb,
  input  logic [1:0]                    l2cache_mem_size,
  output logic                          mem_l2cache_addrOK_r,
  output logic                          mem_l2cache_addrOK_w,
  output logic                          mem_l2cache_dataOK,
  output logic [31:0]                   m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [31:0]                   m_axi_rdata,
  input  logic                          m_axi_rvalid,
  input  logic                          m_axi_rlast,
  output logic                          m_axi_rready,
  output logic [31:0]                   m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [31:0]                   m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [2:0]                    dbg_state
);

  localparam int LW = 32 << offset_width;
  localparam int CW = offset_width + 1;
  localparam logic [CW-1:0] FULL_LEN = CW'((1 << offset_width) - 1);
  localparam logic [31:0] OFF_MASK = 32'((1 << (offset_width + 2)) - 1);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, ACK} state_t;

  state_t state, state_nx;

  logic [31:0]             addr_q;
  logic [LW-1:0]           wline_q;
  logic [LW-1:0]           din_q;
  logic [3:0]              wstrb_q;
  logic [2:0]              size_q;
  logic [CW-1:0]           len_q;
  logic [CW-1:0]           cnt_q;
  logic [offset_width-1:0] idx;
  logic                    cnt_last;
  logic [31:0]             sel_addr;

  assign idx      = cnt_q[offset_width-1:0];
  assign cnt_last = (cnt_q == len_q);
  assign sel_addr = l2cache_mem_req_w ? addr_l2cache_mem_w : addr_l2cache_mem_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Handshakes: a beat moves on a rising edge where valid && ready are both
  // high; valid (and its payload) stays put until that edge, and ready/valid
  // driven by this block depend only on state, never on the partner's signal.
  always_comb begin
    state_nx             = state;
    mem_l2cache_addrOK_r = 1'b0;
    mem_l2cache_addrOK_w = 1'b0;
    mem_l2cache_dataOK   = 1'b0;
    m_axi_arvalid        = 1'b0;
    m_axi_rready         = 1'b0;
    m_axi_awvalid        = 1'b0;
    m_axi_wvalid         = 1'b0;
    m_axi_wlast          = 1'b0;
    m_axi_bready         = 1'b0;
    case (state)
      IDLE: begin
        // Write wins so a writeback lands before the refill that replaces it.
        if (rstn && l2cache_mem_req_w) begin
          mem_l2cache_addrOK_w = 1'b1;
          state_nx             = AW;
        end else if (rstn && l2cache_mem_req_r) begin
          mem_l2cache_addrOK_r = 1'b1;
          state_nx             = AR;
        end
      end
      AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nx = R;
      end
      R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && (m_axi_rlast || cnt_last)) state_nx = ACK;
      end
      AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nx = W;
      end
      W: begin
        m_axi_wvalid = 1'b1;
        m_axi_wlast  = cnt_last;
        if (m_axi_wready && cnt_last) state_nx = B;
      end
      B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nx = ACK;
      end
      ACK: begin
        mem_l2cache_dataOK = 1'b1;
        if (l2cache_mem_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      wline_q <= '0;
      din_q   <= '0;
      wstrb_q <= '0;
      size_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (l2cache_mem_req_w || l2cache_mem_req_r) begin
            addr_q  <= l2cache_mem_SUC ? sel_addr : (sel_addr & ~OFF_MASK);
            wstrb_q <= l2cache_mem_SUC ? l2cache_mem_wstrb : 4'hF;
            size_q  <= l2cache_mem_SUC ? {1'b0, l2cache_mem_size} : 3'd2;
            len_q   <= l2cache_mem_SUC ? '0 : FULL_LEN;
            cnt_q   <= '0;
            // Clearing din on a read start zero-fills the unused words of an uncached read.
            if (l2cache_mem_req_w) wline_q <= dout_l2cache_mem;
            else                   din_q   <= '0;
          end
        end
        R: begin
          if (m_axi_rvalid) begin
            din_q[{idx, 5'b00000} +: 32] <= m_axi_rdata;
            if (!cnt_last) cnt_q <= cnt_q + 1'b1;
          end
        end
        W: begin
          if (m_axi_wready && !cnt_last) cnt_q <= cnt_q + 1'b1;
        end
        ACK: begin
          if (l2cache_mem_rdy) cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign din_mem_l2cache = din_q;
  assign m_axi_araddr    = addr_q;
  assign m_axi_awaddr    = addr_q;
  assign m_axi_arlen     = {{(8-CW){1'b0}}, len_q};
  assign m_axi_awlen     = {{(8-CW){1'b0}}, len_q};
  assign m_axi_arsize    = size_q;
  assign m_axi_awsize    = size_q;
  assign m_axi_arburst   = 2'b01;
  assign m_axi_awburst   = 2'b01;
  assign m_axi_wdata     = wline_q[{idx, 5'b00000} +: 32];
  assign m_axi_wstrb     = wstrb_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_l2_axi_bridge.sv
// Directed bench for l2_axi_bridge: driver tasks act as L2 and AXI slave,
// a negedge monitor pops expected AR/AW/W/ack entries from queues and compares.
module tb_l2_axi_bridge;

  localparam int OW = 3;
  localparam int LW = 32 << OW;

  logic          clk;
  logic          rstn;
  logic [31:0]   addr_r, addr_w;
  logic [LW-1:0] dout, din;
  logic          req_r, req_w, rdy, suc;
  logic [3:0]    strb;
  logic [1:0]    size;
  logic          addrok_r, addrok_w, dataok;
  logic [31:0]   araddr, awaddr, rdata, wdata;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize, dbg_state;
  logic [1:0]    arburst, awburst;
  logic          arvalid, arready, rvalid, rlast, rready;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]    wstrb;

  l2_axi_bridge #(.offset_width(OW)) dut (
    .clk(clk), .rstn(rstn),
    .addr_l2cache_mem_r(addr_r), .addr_l2cache_mem_w(addr_w),
    .dout_l2cache_mem(dout), .din_mem_l2cache(din),
    .l2cache_mem_req_r(req_r), .l2cache_mem_req_w(req_w),
    .l2cache_mem_rdy(rdy), .l2cache_mem_SUC(suc),
    .l2cache_mem_wstrb(strb), .l2cache_mem_size(size),
    .mem_l2cache_addrOK_r(addrok_r), .mem_l2cache_addrOK_w(addrok_w),
    .mem_l2cache_dataOK(dataok),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rvalid(rvalid), .m_axi_rlast(rlast), .m_axi_rready(rready),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [42:0]   exp_ar_q[$];   // {addr, len, size}
  logic [42:0]   exp_aw_q[$];
  logic [36:0]   exp_w_q[$];    // {data, strb, last}
  logic [LW-1:0] exp_ack_q[$];  // din while dataOK handshakes
  logic [LW-1:0] last_din;
  int n_checks = 0;
  int n_errors = 0;
  int t_addr, t_ack;

  task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout/unexpected expected handshake", name);
  endtask

  logic          p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_dok, p_rdy, p_wlast;
  logic [31:0]   p_araddr, p_awaddr, p_wdata;
  logic [3:0]    p_wstrb;
  logic [LW-1:0] p_din;

  always @(negedge clk) begin
    if (!rstn) begin
      {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_dok, p_rdy} = '0;
    end else begin
      if (arvalid && arready) begin
        if (exp_ar_q.size() == 0) fail("ar_unexpected");
        else check("ar", {araddr, arlen, arsize, arburst}, {exp_ar_q.pop_front(), 2'b01});
      end
      if (awvalid && awready) begin
        if (exp_aw_q.size() == 0) fail("aw_unexpected");
        else check("aw", {awaddr, awlen, awsize, awburst}, {exp_aw_q.pop_front(), 2'b01});
      end
      if (wvalid && wready) begin
        if (exp_w_q.size() == 0) fail("w_unexpected");
        else check("w_beat", {wdata, wstrb, wlast}, exp_w_q.pop_front());
      end
      if (dataok && rdy) begin
        if (exp_ack_q.size() == 0) fail("ack_unexpected");
        else check("ack_din", din, exp_ack_q.pop_front());
      end
      if (p_arv && !p_arr) check("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
      if (p_awv && !p_awr) check("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_wv && !p_wr) check("w_stable", {wvalid, wdata, wstrb, wlast}, {1'b1, p_wdata, p_wstrb, p_wlast});
      if (p_dok && !p_rdy) check("dataok_stable", {dataok, din}, {1'b1, p_din});
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb; p_wlast = wlast;
      p_dok = dataok; p_rdy = rdy; p_din = din;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < (1 << OW); k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic wait_addr_ok(input bit is_w);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (is_w ? addrok_w : addrok_r) begin
        seen = 1'b1;
        t_addr = cyc;
        check("addrok_other", is_w ? addrok_r : addrok_w, 0);
      end
      @(posedge clk); #1;
    end
    if (is_w) req_w = 1'b0; else req_r = 1'b0;
    if (!seen) fail("addrok_timeout");
    else check("addrok_pulse", is_w ? addrok_w : addrok_r, 0);
  endtask

  // ch: 0=AR 1=R 2=AW 3=W 4=B; n handshakes, optionally with random stalls
  task automatic serve(input int ch, input int n, input bit bp, input logic [LW-1:0] rline);
    int got;
    bit hs, go;
    got = 0;
    for (int i = 0; i < 500 && got < n; i++) begin
      go = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      case (ch)
        0: arready = go;
        1: begin rvalid = go; rdata = rline[32*got +: 32]; rlast = (got == n - 1); end
        2: awready = go;
        3: wready = go;
        default: bvalid = go;
      endcase
      @(negedge clk);
      case (ch)
        0: hs = arvalid && arready;
        1: hs = rvalid && rready;
        2: hs = awvalid && awready;
        3: hs = wvalid && wready;
        default: hs = bvalid && bready;
      endcase
      if (hs) got++;
      @(posedge clk); #1;
    end
    {arready, rvalid, rlast, awready, wready, bvalid} = '0;
    if (got < n) fail("serve_timeout");
  endtask

  task automatic do_ack(input int rdy_low);
    bit seen;
    int n;
    seen = 1'b0;
    rdy = (rdy_low == 0);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (dataok) begin seen = 1'b1; t_ack = cyc; end
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin
      fail("ack_timeout");
      rdy = 1'b1;
      return;
    end
    n = 1;
    for (int i = 0; i < rdy_low; i++) begin
      @(posedge clk); #1;
      if (i == rdy_low - 1) rdy = 1'b1;
      @(negedge clk);
      if (dataok) n++;
    end
    if (rdy_low > 0) check("dataok_hold", n, rdy_low + 1);
    @(posedge clk); #1;
    check("dataok_drop", dataok, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input bit s, input logic [1:0] sz,
                         input logic [42:0] e_ar, input logic [LW-1:0] rline, input int n,
                         input logic [LW-1:0] e_din, input bit bp, input int rdy_low);
    exp_ar_q.push_back(e_ar);
    exp_ack_q.push_back(e_din);
    last_din = e_din;
    addr_r = a; suc = s; size = sz; req_r = 1'b1;
    wait_addr_ok(1'b0);
    serve(0, 1, bp, '0);
    serve(1, n, bp, rline);
    do_ack(rdy_low);
  endtask

  task automatic do_write(input logic [31:0] a, input bit s, input logic [1:0] sz,
                          input logic [3:0] st, input logic [LW-1:0] line,
                          input logic [42:0] e_aw, input int n, input logic [3:0] e_strb,
                          input bit bp, input int rdy_low);
    exp_aw_q.push_back(e_aw);
    for (int k = 0; k < n; k++) exp_w_q.push_back({line[32*k +: 32], e_strb, k == n - 1});
    exp_ack_q.push_back(last_din);
    addr_w = a; suc = s; size = sz; strb = st; dout = line; req_w = 1'b1;
    wait_addr_ok(1'b1);
    serve(2, 1, bp, '0);
    serve(3, n, bp, '0);
    serve(4, 1, 1'b0, '0);
    do_ack(rdy_low);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn = 1'b0;
    {addr_r, addr_w, dout, req_r, req_w, suc, strb, size} = '0;
    rdy = 1'b1;
    {arready, rdata, rvalid, rlast, awready, wready, bvalid} = '0;
    last_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {arvalid, awvalid, wvalid, rready, bready, wlast, addrok_r, addrok_w, dataok}, 0);
    check("reset_din", din, 0);
    check("reset_state", dbg_state, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // cached read, zero-wait slave, line offset bits dropped
    do_read(32'h1C00_0014, 1'b0, 2'd2, {32'h1C00_0000, 8'd7, 3'd2}, mk_line(32'h0),
            8, mk_line(32'h0), 1'b0, 0);
    check("rd_latency", t_ack - t_addr, 10);

    // cached write, words 0xA0..0xA7
    do_write(32'h8000_0020, 1'b0, 2'd2, 4'h0, mk_line(32'hA0),
             {32'h8000_0020, 8'd7, 3'd2}, 8, 4'hF, 1'b0, 0);
    check("wr_latency", t_ack - t_addr, 11);

    // uncached byte write: address, size and strobes pass through
    do_write(32'hBFD0_0003, 1'b1, 2'd0, 4'b1000, {{7{32'hFFFF_FFFF}}, 32'h5A00_0000},
             {32'hBFD0_0003, 8'd0, 3'd0}, 1, 4'b1000, 1'b0, 0);

    // uncached word read: upper words of din zero-filled
    do_read(32'h1FC0_0004, 1'b1, 2'd2, {32'h1FC0_0004, 8'd0, 3'd2}, mk_line(32'hDEAD_BEEF),
            1, {{7{32'h0}}, 32'hDEAD_BEEF}, 1'b0, 0);

    // read and write requested together: write first, then the read
    exp_aw_q.push_back({32'h4000_0040, 8'd7, 3'd2});
    for (int k = 0; k < 8; k++) exp_w_q.push_back({32'hC0 + 32'(k), 4'hF, k == 7});
    exp_ack_q.push_back(last_din);
    exp_ar_q.push_back({32'h4000_1000, 8'd7, 3'd2});
    exp_ack_q.push_back(mk_line(32'hD0));
    last_din = mk_line(32'hD0);
    addr_w = 32'h4000_0040; addr_r = 32'h4000_1000; dout = mk_line(32'hC0);
    suc = 1'b0; size = 2'd2; req_w = 1'b1; req_r = 1'b1;
    wait_addr_ok(1'b1);
    serve(2, 1, 1'b0, '0);
    serve(3, 8, 1'b0, '0);
    serve(4, 1, 1'b0, '0);
    do_ack(0);
    wait_addr_ok(1'b0);
    serve(0, 1, 1'b0, '0);
    serve(1, 8, 1'b0, mk_line(32'hD0));
    do_ack(0);

    // backpressure on every channel plus a slow L2
    do_read(32'h2000_0100, 1'b0, 2'd2, {32'h2000_0100, 8'd7, 3'd2}, mk_line(32'h1111_0000),
            8, mk_line(32'h1111_0000), 1'b1, 5);
    do_write(32'h3000_0044, 1'b0, 2'd2, 4'h0, mk_line(32'hB0),
             {32'h3000_0040, 8'd7, 3'd2}, 8, 4'hF, 1'b1, 3);

    // reset during beat 4 of a read abandons it
    exp_ar_q.push_back({32'h0000_1040, 8'd7, 3'd2});
    addr_r = 32'h0000_105C; suc = 1'b0; req_r = 1'b1;
    wait_addr_ok(1'b0);
    serve(0, 1, 1'b0, '0);
    serve(1, 3, 1'b0, mk_line(32'h77));
    rvalid = 1'b1; rdata = 32'h7A;
    #2 rstn = 1'b0;
    #1;
    check("midreset_ctrl", {arvalid, awvalid, wvalid, rready, bready, wlast, addrok_r, addrok_w, dataok}, 0);
    check("midreset_din", din, 0);
    check("midreset_state", dbg_state, 0);
    rvalid = 1'b0;
    last_din = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    do_read(32'h0000_1040, 1'b0, 2'd2, {32'h0000_1040, 8'd7, 3'd2}, mk_line(32'h300),
            8, mk_line(32'h300), 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("ar_q_empty", exp_ar_q.size(), 0);
    check("aw_q_empty", exp_aw_q.size(), 0);
    check("w_q_empty", exp_w_q.size(), 0);
    check("ack_q_empty", exp_ack_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
